pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Owns the architectural PC register of the 16-bit pipelined core and sequences instruction fetch.
- Issues fetch requests to a variable-latency instruction memory and advances the PC by 2.
- Applies taken-branch redirects resolved in EX, together with the IF/ID and ID/EX flushes.
- Freezes on load-use stalls and halts on HLT.
- Sits between the hazard unit / EX branch-condition logic and the IF stage.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
PC_W, 16, PC/address width

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
stall  in  1  load-use stall from hazard unit; hold PC and IF/ID
br_valid  in  1  branch/jump instruction resolved in EX this cycle
br_taken  in  1  resolved condition met (qualified by br_valid)
br_target  in  PC_W  resolved target (PC-relative or register), bit0 ignored
hlt_dec  in  1  HLT opcode decoded in ID this cycle
imem_ready  in  1  instruction memory returns the data for the outstanding request
imem_req  out  1  fetch request valid
imem_addr  out  PC_W  fetch address, equal to pc
pc  out  PC_W  current fetch PC
ifid_we  out  1  write enable for the IF/ID pipeline register
flush_ifid  out  1  bubble IF/ID
flush_idex  out  1  bubble ID/EX
halted  out  1  core halted
br_cnt  out  16  resolved-branch counter (see Optional Feature)
br_taken_cnt  out  16  taken-branch counter (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): pc=RESET_PC, state=FETCH, counters=0.
- While rst_n is low: imem_req, ifid_we, flush_* and halted are all 0.
- States: FETCH, WAIT_MEM, DRAIN, HALT. Registered state; outputs are combinational from state and inputs.
- redirect = br_valid & br_taken. Priority: redirect > hlt_dec > stall > normal.
- FETCH:
  - imem_req=1.
  - If imem_ready & ~stall: ifid_we=1, pc<=pc+2 (mod 2^16; 16'hFFFE wraps to 16'h0000).
  - If imem_ready & stall: data is dropped, pc held, ifid_we=0. The same address is refetched next cycle.
  - If ~imem_ready: go to WAIT_MEM with pc held.
- WAIT_MEM:
  - imem_req=1, pc held.
  - On imem_ready, apply the same rules as FETCH, then return to FETCH.
- Redirect in any non-HALT state:
  - flush_ifid=1 and flush_idex=1 in the same cycle; ifid_we=0.
  - pc<={br_target[15:1],1'b0}.
  - Any instruction returned this cycle is discarded.
  - From FETCH or WAIT_MEM with imem_ready=1: go to FETCH.
  - From WAIT_MEM with imem_ready=0: go to DRAIN, because a stale request is outstanding.
- DRAIN:
  - imem_req=0, ifid_we=0.
  - Wait for imem_ready, discard the data, then go to FETCH at the new pc.
  - A second redirect while in DRAIN overwrites pc and stays in DRAIN.
- hlt_dec (no redirect):
  - If ~stall: flush_ifid=1, state<=HALT, pc held.
  - If stall: ignored this cycle; HLT is re-presented.
- HALT:
  - imem_req=0, ifid_we=0, flush_*=0, halted=1. PC is frozen.
  - Terminal until reset. br_valid is ignored, because older instructions have already resolved.
- redirect and hlt_dec in the same cycle: redirect wins. HLT is on the wrong path and is flushed.
- redirect and stall in the same cycle: redirect wins, and the stall is ignored for the PC.
- rst_n asserted mid-fetch or mid-drain: immediate return to reset values. Any outstanding memory response is the memory's responsibility.

Optional Feature:
Macro PC_SEQ_PERF_CNT_EN.
- Defined:
  - br_cnt increments on br_valid while not in HALT.
  - br_taken_cnt increments on redirect.
  - Both are 16-bit, saturate at 16'hFFFF and reset to 0.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Decomposition:
- Package pc_seq_pkg holds:
  - state enum {FETCH, WAIT_MEM, DRAIN, HALT}
  - PC_W
  - PC_INC=16'd2
  - RESET_PC default
- Sub-module pc_perf_cnt (one instance per counter: saturating 16-bit increment with async active-low clear), instantiated only under PC_SEQ_PERF_CNT_EN.

Test Plan:
- Reset, then imem_ready tied 1 for 4 cycles -> pc 0000,0002,0004,0006; ifid_we=1 each cycle; imem_req=0 during reset.
- imem_ready low 3 cycles at pc=0x0010 -> pc held 0x0010, imem_req=1; ready on cycle 4 -> pc=0x0012, ifid_we pulses once.
- In WAIT_MEM, br_valid=br_taken=1, br_target=0x0101 -> flush_ifid=flush_idex=1, pc=0x0100, DRAIN. Stale ready 2 cycles later is discarded, then fetch at 0x0100.
- pc=0xFFFE, ready=1 -> pc=0x0000. Same cycle as stall=1 -> pc stays 0xFFFE, ifid_we=0.
- hlt_dec together with redirect to 0x0040 -> no halt, pc=0x0040. Later hlt_dec alone -> halted=1, imem_req=0, pc frozen over 10 cycles of br_valid pulses.
- PC_SEQ_PERF_CNT_EN: 5 br_valid, 3 taken -> br_cnt=5, br_taken_cnt=3. Force 70000 taken -> both saturate at 0xFFFF.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the PC sequencer
package pc_seq_pkg;
    localparam int PC_W = 16;
    localparam int CNT_W = 16;
    localparam logic [15:0] PC_INC = 16'd2;
    localparam logic [15:0] RESET_PC = 16'h0000;
    typedef enum logic [1:0] {FETCH, WAIT_MEM, DRAIN, HALT} state_t;
endpackage

// File: rtl/pc_perf_cnt.sv
// pc_perf_cnt: saturating event counter with asynchronous active-low clear
module pc_perf_cnt
    import pc_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register and fetch sequencing; PC_SEQ_PERF_CNT_EN adds branch counters
module pc_sequencer #(
    parameter int              PC_W     = pc_seq_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(pc_seq_pkg::RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            br_valid,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            hlt_dec,
    input  logic            imem_ready,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    output logic [PC_W-1:0] pc,
    output logic            ifid_we,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            halted,
    output logic [15:0]     br_cnt,
    output logic [15:0]     br_taken_cnt
);
    import pc_seq_pkg::*;

    state_t          state, state_nx;
    logic [PC_W-1:0] pc_nx;
    logic            active, redirect, req_b, we_b, fi_b, fx_b;
    logic            unused_ok;

    assign active    = state != HALT;
    assign redirect  = br_valid & br_taken & active;
    assign unused_ok = br_target[0];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
        end

    // a redirect with no response yet leaves a stale request in flight, so drain it
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        req_b    = state == FETCH || state == WAIT_MEM;
        we_b     = 1'b0;
        fi_b     = 1'b0;
        fx_b     = 1'b0;
        if (redirect) begin
            fi_b     = 1'b1;
            fx_b     = 1'b1;
            pc_nx    = {br_target[PC_W-1:1], 1'b0};
            state_nx = imem_ready ? FETCH : DRAIN;
        end else if (active && hlt_dec && !stall) begin
            fi_b     = 1'b1;
            state_nx = HALT;
        end else if (state == DRAIN) begin
            state_nx = imem_ready ? FETCH : DRAIN;
        end else if (active) begin
            state_nx = imem_ready ? FETCH : WAIT_MEM;
            we_b     = imem_ready & ~stall;
            pc_nx    = (imem_ready && !stall) ? pc + PC_W'(PC_INC) : pc;
        end
    end

    assign imem_req   = rst_n & req_b;
    assign ifid_we    = rst_n & we_b;
    assign flush_ifid = rst_n & fi_b;
    assign flush_idex = rst_n & fx_b;
    assign halted     = rst_n & (state == HALT);
    assign imem_addr  = pc;

`ifdef PC_SEQ_PERF_CNT_EN
    pc_perf_cnt u_br_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_valid & active),
        .cnt   (br_cnt)
    );
    pc_perf_cnt u_br_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect),
        .cnt   (br_taken_cnt)
    );
`else
    assign br_cnt       = '0;
    assign br_taken_cnt = '0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: random and directed checks of pc_sequencer against a behavioural model
module tb_pc_sequencer;
    logic        clk = 0;
    logic        rst_n, stall, br_valid, br_taken, hlt_dec, imem_ready;
    logic [15:0] br_target;
    logic        imem_req, ifid_we, flush_ifid, flush_idex, halted;
    logic [15:0] imem_addr, pc, br_cnt, br_taken_cnt;

    int n_chk = 0;
    int n_fail = 0;

    int  m_pc, m_bc, m_tc;
    bit  m_halt, m_drain;
    bit  redir, hlt, fetch, exp_we;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .br_valid     (br_valid),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .hlt_dec      (hlt_dec),
        .imem_ready   (imem_ready),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .pc           (pc),
        .ifid_we      (ifid_we),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .halted       (halted),
        .br_cnt       (br_cnt),
        .br_taken_cnt (br_taken_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Model: fetching unless halted or draining a stale request; WAIT_MEM is indistinguishable from FETCH here.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_outs", {imem_req, ifid_we, flush_ifid, flush_idex, halted}, 0);
            chk("rst_pc", pc, 0);
            chk("rst_cnt", {br_cnt, br_taken_cnt}, 0);
            m_pc = 0; m_bc = 0; m_tc = 0; m_halt = 0; m_drain = 0;
        end else begin
            redir  = br_valid && br_taken && !m_halt;
            hlt    = !m_halt && !redir && hlt_dec && !stall;
            fetch  = !m_halt && !m_drain;
            exp_we = fetch && !redir && !hlt && imem_ready && !stall;
            chk("pc", pc, m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("imem_req", imem_req, fetch);
            chk("ifid_we", ifid_we, exp_we);
            chk("flush_ifid", flush_ifid, redir || hlt);
            chk("flush_idex", flush_idex, redir);
            chk("halted", halted, m_halt);
`ifdef PC_SEQ_PERF_CNT_EN
            chk("br_cnt", br_cnt, m_bc);
            chk("br_taken_cnt", br_taken_cnt, m_tc);
            if (br_valid && !m_halt && m_bc < 65535) m_bc++;
            if (redir && m_tc < 65535) m_tc++;
`else
            chk("br_cnt", br_cnt, 0);
            chk("br_taken_cnt", br_taken_cnt, 0);
`endif
            if (redir) begin
                m_pc    = br_target & 16'hFFFE;
                m_drain = !imem_ready;
            end else if (hlt) m_halt = 1;
            else if (m_drain) m_drain = !imem_ready;
            else if (exp_we) m_pc = (m_pc + 2) % 65536;
        end
    end

    task automatic rnd_inputs;
        imem_ready = $urandom_range(0, 3) != 0;
        stall      = $urandom_range(0, 3) == 0;
        br_valid   = $urandom_range(0, 5) == 0;
        br_taken   = $urandom_range(0, 1) == 1;
        br_target  = 16'($urandom);
        hlt_dec    = $urandom_range(0, 49) == 0;
    endtask

    task automatic idle_inputs;
        stall = 0; br_valid = 0; br_taken = 0; br_target = 0; hlt_dec = 0; imem_ready = 1;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        imem_ready = 0;
        repeat (2) cyc();
        chk("lit_rst_req", imem_req, 0);
        chk("lit_rst_pc", pc, 16'h0000);
        rst_n = 1;
        imem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #2 chk("lit_seq_pc", pc, 2 * i);
            chk("lit_seq_we", ifid_we, 1);
            cyc();
        end
        repeat (4) cyc();
        imem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #2 chk("lit_wait_pc", pc, 16'h0010);
            chk("lit_wait_req", imem_req, 1);
            chk("lit_wait_we", ifid_we, 0);
            cyc();
        end
        imem_ready = 1;
        #2 chk("lit_ready_we", ifid_we, 1);
        cyc();
        chk("lit_ready_pc", pc, 16'h0012);
        imem_ready = 0;
        #2 chk("lit_once_we", ifid_we, 0);
        cyc();
        br_valid = 1; br_taken = 1; br_target = 16'h0101;
        #2 chk("lit_redir_fi", flush_ifid, 1);
        chk("lit_redir_fx", flush_idex, 1);
        chk("lit_redir_we", ifid_we, 0);
        cyc();
        br_valid = 0; br_taken = 0;
        #2 chk("lit_drain_pc", pc, 16'h0100);
        chk("lit_drain_req", imem_req, 0);
        cyc();
        imem_ready = 1;
        #2 chk("lit_stale_we", ifid_we, 0);
        chk("lit_stale_req", imem_req, 0);
        cyc();
        #2 chk("lit_refetch_req", imem_req, 1);
        chk("lit_refetch_pc", pc, 16'h0100);
        chk("lit_refetch_we", ifid_we, 1);
        cyc();
        chk("lit_refetch_next", pc, 16'h0102);
        br_valid = 1; br_taken = 1; br_target = 16'hFFFF;
        cyc();
        br_valid = 0; br_taken = 0;
        chk("lit_top_pc", pc, 16'hFFFE);
        stall = 1;
        #2 chk("lit_stall_we", ifid_we, 0);
        cyc();
        chk("lit_stall_pc", pc, 16'hFFFE);
        stall = 0;
        cyc();
        chk("lit_wrap_pc", pc, 16'h0000);

        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < 300; c++) begin
                rnd_inputs();
                cyc();
            end
            rst_n = 0;
            repeat (2) begin
                rnd_inputs();
                cyc();
            end
            rst_n = 1;
        end

        idle_inputs();
        br_valid = 1; br_taken = 1; br_target = 16'h0040; hlt_dec = 1;
        #2 chk("lit_hlt_redir_fx", flush_idex, 1);
        cyc();
        chk("lit_hlt_redir_halted", halted, 0);
        chk("lit_hlt_redir_pc", pc, 16'h0040);
        br_valid = 0; br_taken = 0;
        #2 chk("lit_hlt_fi", flush_ifid, 1);
        cyc();
        hlt_dec = 0;
        for (int i = 0; i < 10; i++) begin
            br_valid = 1; br_taken = $urandom_range(0, 1) == 1; br_target = 16'($urandom);
            #2 chk("lit_halt_halted", halted, 1);
            chk("lit_halt_req", imem_req, 0);
            chk("lit_halt_pc", pc, 16'h0040);
            cyc();
        end

        rst_n = 0;
        idle_inputs();
        cyc();
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            br_valid = 1; br_taken = i < 3; br_target = 16'h0200;
            cyc();
        end
        br_valid = 0; br_taken = 0;
        #2;
`ifdef PC_SEQ_PERF_CNT_EN
        chk("lit_br_cnt", br_cnt, 5);
        chk("lit_br_taken_cnt", br_taken_cnt, 3);
        br_valid = 1; br_taken = 1;
        repeat (70000) cyc();
        br_valid = 0; br_taken = 0;
        #2 chk("lit_br_cnt_sat", br_cnt, 16'hFFFF);
        chk("lit_br_taken_cnt_sat", br_taken_cnt, 16'hFFFF);
`else
        chk("lit_br_cnt_off", br_cnt, 0);
        chk("lit_br_taken_cnt_off", br_taken_cnt, 0);
`endif
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
